adc_frame_sequencer: RTL and testbench
======================================

ADC_FRAME_SEQUENCER -- requirements
Module: adc_frame_sequencer

Interface
REQ-001 Parameter NCH, default 3, number of sigma-delta channels per frame.
REQ-002 Parameter CAL_LOG2, default 5, log2 of frames averaged during offset calibration.
REQ-003 Parameter TIMEOUT, default 255, maximum clock cycles from first channel strobe to frame completion.
REQ-004 c  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_cal  input  1  single-cycle pulse requesting offset calibration (motor current known zero).
REQ-007 ch_d  input  16*NCH  filtered ADC words, channel k at bits [16k+15:16k], unsigned.
REQ-008 ch_dv  input  NCH  per-channel single-cycle data-valid strobes, already in c domain.
REQ-009 out_d  output  16*NCH  offset-corrected words, two's-complement signed, same packing as ch_d.
REQ-010 out_dv  output  1  single-cycle strobe, out_d valid.
REQ-011 cal_done  output  1  high while offsets hold a completed calibration.
REQ-012 busy_cal  output  1  high while in CAL state.
REQ-013 timeout_err  output  1  sticky: a frame was dropped by timeout.
REQ-014 overrun_err  output  1  sticky: a channel strobed twice within one frame.

Function
REQ-015 FSM states IDLE, CAL, RUN; reset -> IDLE.
REQ-016 IDLE: frames assembled and emitted with all offsets = 0; start_cal -> CAL.
REQ-017 On ch_dv[k], ch_d[k] latched into slot k and pending bit k set; several channels may strobe in the same cycle.
REQ-018 Frame complete when all NCH pending bits set (including the cycle the last bit is set); pending mask cleared that cycle.
REQ-019 RUN/IDLE: out_dv asserted exactly 1 cycle after completion cycle; out_d[k] = sat16(slot[k] - offset[k]), computed 17-bit signed, saturated to [-32768, 32767].
REQ-020 Strobe on already-pending channel: slot overwritten with new word, overrun_err set.
REQ-021 CAL: entering clears per-channel 16+CAL_LOG2-bit accumulators, frame counter and pending mask; out_dv held 0.
REQ-022 CAL: each completed frame adds slot[k] to accumulator k; after 2^CAL_LOG2 frames, offset[k] = accumulator[k] >> CAL_LOG2, cal_done = 1, -> RUN, next cycle.
REQ-023 start_cal in CAL restarts calibration; in RUN -> CAL, offsets retained until new calibration completes, cal_done cleared on entry.
REQ-024 start_cal coincident with a frame completion: start_cal wins; frame discarded, no out_dv.
REQ-025 Timeout counter starts at first pending bit set, counts while mask nonzero and incomplete; reaching TIMEOUT clears mask, drops partial frame, sets timeout_err; strobes that cycle start a new frame.
REQ-026 A timed-out frame in CAL is not counted toward 2^CAL_LOG2.
REQ-027 Sticky errors cleared only by rst or start_cal.

Reset
REQ-028 rst: state IDLE, out_d 0, out_dv 0, cal_done 0, busy_cal 0, timeout_err 0, overrun_err 0, offsets 0, pending mask 0, counters 0.
REQ-029 rst overrides all inputs in same cycle; mid-frame or mid-calibration data discarded.

Configuration
REQ-030 Macro ADC_FRAME_SEQUENCER_TIMEOUT_EN defined: REQ-025/026 timeout logic present.
REQ-031 Macro undefined: no timeout counter, timeout_err tied 0, partial frames wait indefinitely.

Structure
REQ-032 Package adc_frame_seq_pkg holds state enum, word width 16, default NCH/CAL_LOG2/TIMEOUT constants.
REQ-033 Sub-module adc_offset_sat (one 16-bit subtract-and-saturate), instantiated NCH times.

Verification
REQ-034 Strobe ch0,ch1,ch2 at cycles 0,3,5 with 1000,2000,3000, IDLE -> out_dv at cycle 6, out_d = 1000,2000,3000.
REQ-035 start_cal, 32 frames all channels 16400 -> cal_done at frame 32, RUN; next frame 16410,16390,16400 -> out_d = 10,-10,0.
REQ-036 Offset 40000 on ch0, input 0 -> out_d[0] = -32768; offset 0, input 65535 -> 32767.
REQ-037 Only ch0 and ch1 strobe, TIMEOUT = 255 -> 255 cycles after first strobe mask clears, timeout_err = 1, no out_dv; with macro undefined, no error and frame completes when ch2 arrives.
REQ-038 ch0 strobes twice (100 then 200) before ch1/ch2 -> overrun_err = 1, out_d[0] = 200.
REQ-039 rst asserted at calibration frame 10 -> IDLE, cal_done 0, offsets 0; next frame passes uncorrected.

Source files
------------

// File: rtl/adc_frame_seq_pkg.sv
// adc_frame_seq_pkg
// Shared definitions for the ADC frame sequencer:
//   - sequencer state encoding (IDLE / CAL / RUN)
//   - ADC word width and default NCH / CAL_LOG2 / TIMEOUT values
//   - sat_to_word(): clamps a 17-bit signed difference to a 16-bit signed word
package adc_frame_seq_pkg;

  localparam int WORD_W       = 16;
  localparam int DEF_NCH      = 3;
  localparam int DEF_CAL_LOG2 = 5;
  localparam int DEF_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Clamp a 17-bit two's-complement value to [-32768, 32767].
  function automatic logic [WORD_W-1:0] sat_to_word(input logic signed [WORD_W:0] v);
    if (v > 17'sd32767)
      return 16'h7FFF;
    else if (v < -17'sd32768)
      return 16'h8000;
    else
      return v[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/adc_offset_sat.sv
// adc_offset_sat
// Subtracts an unsigned offset from an unsigned ADC sample and saturates the
// signed result to 16 bits. Purely combinational.
// Ports:
//   i_sample  [15:0]  unsigned filtered ADC word
//   i_offset  [15:0]  unsigned calibration offset
//   o_result  [15:0]  two's-complement, saturated sample - offset
module adc_offset_sat
  import adc_frame_seq_pkg::*;
(
  input  logic [WORD_W-1:0] i_sample,
  input  logic [WORD_W-1:0] i_offset,
  output logic [WORD_W-1:0] o_result
);

  // Both operands zero-extended, so the difference spans [-65535, 65535],
  // which fits exactly in 17-bit signed.
  logic signed [WORD_W:0] w_diff;

  assign w_diff   = $signed({1'b0, i_sample}) - $signed({1'b0, i_offset});
  assign o_result = sat_to_word(w_diff);

endmodule

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer
// Collects one word per sigma-delta channel into a frame, then either emits the
// offset-corrected frame (IDLE/RUN) or accumulates it into the offset average
// (CAL). Optional frame timeout enabled by macro ADC_FRAME_SEQUENCER_TIMEOUT_EN.
// Ports:
//   c            clock, all logic on rising edge
//   rst          synchronous active-high reset
//   start_cal    pulse: start (or restart) offset calibration
//   ch_d         NCH packed unsigned 16-bit words, channel k at [16k+15:16k]
//   ch_dv        per-channel single-cycle data-valid strobes
//   out_d        NCH packed signed corrected words
//   out_dv       single-cycle strobe, out_d valid
//   cal_done     offsets hold a completed calibration
//   busy_cal     calibration in progress
//   timeout_err  sticky: a partial frame was dropped by timeout
//   overrun_err  sticky: a channel strobed twice within one frame
module adc_frame_sequencer
  import adc_frame_seq_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int CAL_LOG2 = DEF_CAL_LOG2,
  parameter int TIMEOUT  = DEF_TIMEOUT
)(
  input  logic                  c,
  input  logic                  rst,
  input  logic                  start_cal,
  input  logic [WORD_W*NCH-1:0] ch_d,
  input  logic [NCH-1:0]        ch_dv,
  output logic [WORD_W*NCH-1:0] out_d,
  output logic                  out_dv,
  output logic                  cal_done,
  output logic                  busy_cal,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  localparam int ACC_W = WORD_W + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << CAL_LOG2) - 1);

  seq_state_t             r_state;
  logic [NCH-1:0]         r_pend;
  logic [WORD_W-1:0]      r_slot   [NCH];
  logic [WORD_W-1:0]      r_offset [NCH];
  logic [ACC_W-1:0]       r_acc    [NCH];
  logic [CNT_W-1:0]       r_frame_cnt;
  logic [WORD_W*NCH-1:0]  r_out_d;
  logic                   r_out_dv;
  logic                   r_cal_done;
  logic                   r_busy_cal;
  logic                   r_timeout_err;
  logic                   r_overrun_err;

  logic [WORD_W-1:0]      w_frame   [NCH];
  logic [WORD_W-1:0]      w_eff_off [NCH];
  logic [WORD_W-1:0]      w_corr    [NCH];
  logic [ACC_W-1:0]       w_acc_sum [NCH];
  logic [NCH-1:0]         w_pend_all;
  logic                   w_complete;
  logic                   w_overrun;
  logic                   w_timeout;

  // Frame completes in the same cycle the last pending bit would be set, so the
  // frame view forwards words strobing this cycle around the slot registers.
  assign w_pend_all = r_pend | ch_dv;
  assign w_complete = &w_pend_all;
  // A strobe in a timeout cycle opens a fresh frame rather than overrunning.
  assign w_overrun  = (|(r_pend & ch_dv)) && !w_timeout;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_frame[gi]   = ch_dv[gi] ? ch_d[gi*WORD_W +: WORD_W] : r_slot[gi];
      assign w_eff_off[gi] = (r_state == IDLE) ? '0 : r_offset[gi];
      assign w_acc_sum[gi] = r_acc[gi] + ACC_W'(w_frame[gi]);

      adc_offset_sat u_sat (
        .i_sample (w_frame[gi]),
        .i_offset (w_eff_off[gi]),
        .o_result (w_corr[gi])
      );
    end
  endgenerate

`ifdef ADC_FRAME_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counter holds 0 through the first-strobe cycle, so it reads k-1 on the
  // k-th cycle after it; the drop fires exactly TIMEOUT cycles after the
  // first strobe. A completion in that same cycle still wins.
  assign w_timeout = (r_pend != '0) && !w_complete && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge c) begin
    if (rst || start_cal || w_complete || w_timeout || (r_pend == '0))
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge c) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pend        <= '0;
      r_frame_cnt   <= '0;
      r_out_d       <= '0;
      r_out_dv      <= 1'b0;
      r_cal_done    <= 1'b0;
      r_busy_cal    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_slot[k]   <= '0;
        r_offset[k] <= '0;
        r_acc[k]    <= '0;
      end
    end else begin
      r_out_dv <= 1'b0;
      for (int k = 0; k < NCH; k++)
        if (ch_dv[k]) r_slot[k] <= ch_d[k*WORD_W +: WORD_W];

      if (start_cal) begin
        // Restart from any state; a coinciding frame completion is discarded.
        // Offsets stay in force until the new calibration finishes.
        r_state       <= CAL;
        r_busy_cal    <= 1'b1;
        r_cal_done    <= 1'b0;
        r_pend        <= '0;
        r_frame_cnt   <= '0;
        r_timeout_err <= 1'b0;
        r_overrun_err <= 1'b0;
        for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
      end else begin
        if (w_overrun) r_overrun_err <= 1'b1;
        if (w_timeout) r_timeout_err <= 1'b1;

        if (w_complete)     r_pend <= '0;
        else if (w_timeout) r_pend <= ch_dv;
        else                r_pend <= w_pend_all;

        if (w_complete) begin
          if (r_state == CAL) begin
            for (int k = 0; k < NCH; k++) r_acc[k] <= w_acc_sum[k];
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (r_frame_cnt == LAST_FRAME) begin
              for (int k = 0; k < NCH; k++)
                r_offset[k] <= w_acc_sum[k][ACC_W-1:CAL_LOG2];
              r_cal_done <= 1'b1;
              r_busy_cal <= 1'b0;
              r_state    <= RUN;
            end
          end else begin
            r_out_dv <= 1'b1;
            for (int k = 0; k < NCH; k++)
              r_out_d[k*WORD_W +: WORD_W] <= w_corr[k];
          end
        end
      end
    end
  end

  assign out_d       = r_out_d;
  assign out_dv      = r_out_dv;
  assign cal_done    = r_cal_done;
  assign busy_cal    = r_busy_cal;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Self-checking bench for adc_frame_sequencer (NCH=3, CAL_LOG2=5, TIMEOUT=255).
// Expected frames are pushed to a queue as stimulus is issued; a monitor pops
// and compares on every out_dv. Status flags are checked directly.
module tb_adc_frame_sequencer;

  localparam int NCH      = 3;
  localparam int CAL_LOG2 = 5;
  localparam int TIMEOUT  = 255;

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic        start_cal = 1'b0;
  logic [47:0] ch_d = '0;
  logic [2:0]  ch_dv = '0;
  logic [47:0] out_d;
  logic        out_dv;
  logic        cal_done;
  logic        busy_cal;
  logic        timeout_err;
  logic        overrun_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;

  always #5 c = ~c;

  adc_frame_sequencer #(
    .NCH      (NCH),
    .CAL_LOG2 (CAL_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .c           (c),
    .rst         (rst),
    .start_cal   (start_cal),
    .ch_d        (ch_d),
    .ch_dv       (ch_dv),
    .out_d       (out_d),
    .out_dv      (out_dv),
    .cal_done    (cal_done),
    .busy_cal    (busy_cal),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  function automatic logic [47:0] pack3(input int a, input int b, input int d);
    logic [15:0] x, y, z;
    x = a[15:0];
    y = b[15:0];
    z = d[15:0];
    return {z, y, x};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One sampled cycle with the given strobes / start_cal, then idle inputs.
  task automatic drive(input logic [2:0] dv, input logic [47:0] d, input logic sc);
    ch_dv = dv;
    ch_d = d;
    start_cal = sc;
    @(posedge c); #1;
    ch_dv = '0;
    start_cal = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge c); #1;
    end
  endtask

  // Scoreboard monitor: every out_dv must match the oldest expected frame.
  always @(negedge c) begin
    if (out_dv === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_frame: got unexpected frame %h, required no out_dv", out_d);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_d !== mon_exp) begin
          n_fail++;
          $display("FAIL out_frame: got %h, required %h", out_d, mon_exp);
        end else begin
          $display("ok   out_frame: %h", out_d);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge c);
    #1;
    rst = 1'b0;
    chk("rst_out_d", out_d, 48'd0);
    chk("rst_out_dv", 48'(out_dv), 48'd0);
    chk("rst_cal_done", 48'(cal_done), 48'd0);
    chk("rst_busy_cal", 48'(busy_cal), 48'd0);
    chk("rst_timeout_err", 48'(timeout_err), 48'd0);
    chk("rst_overrun_err", 48'(overrun_err), 48'd0);

    // Staggered strobes in IDLE, out_dv one cycle after the last strobe
    drive(3'b001, pack3(1000, 0, 0), 1'b0);
    idle(2);
    drive(3'b010, pack3(0, 2000, 0), 1'b0);
    idle(1);
    exp_q.push_back(pack3(1000, 2000, 3000));
    drive(3'b100, pack3(0, 0, 3000), 1'b0);
    chk("latency_dv_high", 48'(out_dv), 48'd1);
    idle(1);
    chk("dv_single_cycle", 48'(out_dv), 48'd0);

    // Overrun: ch0 strobes twice, second word wins
    drive(3'b001, pack3(100, 0, 0), 1'b0);
    drive(3'b001, pack3(200, 0, 0), 1'b0);
    exp_q.push_back(pack3(200, 5, 7));
    drive(3'b110, pack3(0, 5, 7), 1'b0);
    chk("overrun_err", 48'(overrun_err), 48'd1);

    // Positive saturation with zero offsets, all channels in one cycle
    exp_q.push_back(pack3(32767, 32767, 0));
    drive(3'b111, pack3(65535, 40000, 0), 1'b0);
    idle(1);

    // Partial frame: ch0, ch1 only
    drive(3'b011, pack3(11, 22, 0), 1'b0);
`ifdef ADC_FRAME_SEQUENCER_TIMEOUT_EN
    idle(TIMEOUT - 1);
    chk("timeout_not_yet", 48'(timeout_err), 48'd0);
    idle(1);
    chk("timeout_err_set", 48'(timeout_err), 48'd1);
    drive(3'b100, pack3(0, 0, 55), 1'b0);
    idle(2);
    exp_q.push_back(pack3(33, 44, 55));
    drive(3'b011, pack3(33, 44, 0), 1'b0);
`else
    idle(300);
    chk("no_timeout_err", 48'(timeout_err), 48'd0);
    exp_q.push_back(pack3(11, 22, 55));
    drive(3'b100, pack3(0, 0, 55), 1'b0);
`endif
    idle(1);

    // Calibration: last ch2 frame is 16432, so offset2 = 16401
    drive(3'b000, 48'd0, 1'b1);
    chk("cal_busy", 48'(busy_cal), 48'd1);
    chk("cal_done_cleared", 48'(cal_done), 48'd0);
    chk("overrun_cleared", 48'(overrun_err), 48'd0);
    chk("timeout_cleared", 48'(timeout_err), 48'd0);
    for (int i = 0; i < 32; i++) begin
      drive(3'b111, pack3(16400, 16400, (i == 31) ? 16432 : 16400), 1'b0);
      if (i == 30) chk("cal_done_frame31", 48'(cal_done), 48'd0);
    end
    chk("cal_done_frame32", 48'(cal_done), 48'd1);
    chk("busy_after_cal", 48'(busy_cal), 48'd0);
    exp_q.push_back(pack3(10, -10, -1));
    drive(3'b111, pack3(16410, 16390, 16400), 1'b0);
    idle(1);

    // Recalibrate from RUN; start_cal coincides with a completing frame
    drive(3'b011, pack3(1, 2, 0), 1'b0);
    drive(3'b100, pack3(0, 0, 3), 1'b1);
    chk("recal_done_cleared", 48'(cal_done), 48'd0);
    chk("recal_busy", 48'(busy_cal), 48'd1);
    for (int i = 0; i < 32; i++)
      drive(3'b111, pack3(40000, 0, 65535), 1'b0);
    chk("recal_done", 48'(cal_done), 48'd1);
    exp_q.push_back(pack3(-32768, 32767, -32768));
    drive(3'b111, pack3(0, 65535, 0), 1'b0);
    idle(1);

    // Reset mid-calibration, with a partial frame pending
    drive(3'b000, 48'd0, 1'b1);
    for (int i = 0; i < 10; i++)
      drive(3'b111, pack3(500, 500, 500), 1'b0);
    drive(3'b001, pack3(9, 0, 0), 1'b0);
    rst = 1'b1;
    @(posedge c); #1;
    rst = 1'b0;
    chk("midcal_rst_cal_done", 48'(cal_done), 48'd0);
    chk("midcal_rst_busy", 48'(busy_cal), 48'd0);
    drive(3'b110, pack3(0, 5678, 7), 1'b0);
    idle(1);
    exp_q.push_back(pack3(1234, 5678, 7));
    drive(3'b001, pack3(1234, 0, 0), 1'b0);
    idle(3);

    chk("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
